// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: operand-mux select
// encodings used by the datapath, and the stall sequencer state encoding.
package hazard_fwd_unit_pkg;

    // Operand source selects, shared with the EX-stage operand muxes
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Stall sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Priority pick between the nearer writer (A) and the older writer (B)
    function automatic logic [1:0] fwd_pick(input logic i_matchA, input logic i_matchB);
        logic [1:0] w_sel;
        w_sel = FWD_RF;
        if (i_matchA) begin
            w_sel = FWD_EXMEM;
        end else if (i_matchB) begin
            w_sel = FWD_MEMWB;
        end
        return w_sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_cmp.sv
// Single-operand forwarding comparator. Writer A is the younger pipeline
// stage and wins over writer B; register 0 never produces a match.
module fwd_sel_cmp
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_wrA_en,
    input  logic [REG_AW-1:0] i_wrA_rd,
    input  logic              i_wrB_en,
    input  logic [REG_AW-1:0] i_wrB_rd,
    output logic [1:0]        o_sel
);

    logic w_matchA;
    logic w_matchB;

    assign w_matchA = i_wrA_en && (i_wrA_rd != '0) && (i_wrA_rd == i_rs);
    assign w_matchB = i_wrB_en && (i_wrB_rd != '0) && (i_wrB_rd == i_rs);
    assign o_sel    = fwd_pick(w_matchA, w_matchB);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding, load-use hazard detection and a multi-cycle stall
// sequencer. Forward selects are either computed in EX from ID/EX source
// registers, or computed a stage early in ID and registered into EX.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int REG_FWD  = 0,
    parameter int CNT_W    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
    input  logic                      ex_regwrite_i,
    input  logic                      ex_memread_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      mem_regwrite_i,
    input  logic [REG_AW-1:0]         mem_rd_i,
    input  logic                      wb_regwrite_i,
    input  logic [REG_AW-1:0]         wb_rd_i,
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic [NUM_SRC-1:0]        id_bypass_o,
    output logic                      pc_write_o,
    output logic                      ifid_write_o,
    output logic                      idex_bubble_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    logic                 w_exWriter;
    logic                 w_wbWriter;
    logic [NUM_SRC-1:0]   w_idMatchEx;
    logic [2*NUM_SRC-1:0] w_selCalc;
    logic [2*NUM_SRC-1:0] w_fwdSel;
    logic                 w_hazard;
    logic                 w_stall;
    state_t               r_state;
    state_t               w_stateNext;
    logic [2:0]           r_remain;
    logic [2:0]           w_remainNext;
    logic [CNT_W-1:0]     r_stallCnt;

    assign w_exWriter = ex_regwrite_i && (ex_rd_i != '0);
    assign w_wbWriter = wb_regwrite_i && (wb_rd_i != '0);

    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_src
            logic [REG_AW-1:0] w_idRs;
            assign w_idRs         = id_rs_i[k*REG_AW +: REG_AW];
            assign w_idMatchEx[k] = (ex_rd_i == w_idRs);
            assign id_bypass_o[k] = w_wbWriter && (wb_rd_i == w_idRs);

            if (REG_FWD != 0) begin : g_idcmp
                fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp (
                    .i_rs     (w_idRs),
                    .i_wrA_en (ex_regwrite_i),
                    .i_wrA_rd (ex_rd_i),
                    .i_wrB_en (mem_regwrite_i),
                    .i_wrB_rd (mem_rd_i),
                    .o_sel    (w_selCalc[2*k +: 2])
                );
            end else begin : g_excmp
                fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp (
                    .i_rs     (ex_rs_i[k*REG_AW +: REG_AW]),
                    .i_wrA_en (mem_regwrite_i),
                    .i_wrA_rd (mem_rd_i),
                    .i_wrB_en (wb_regwrite_i),
                    .i_wrB_rd (wb_rd_i),
                    .o_sel    (w_selCalc[2*k +: 2])
                );
            end
        end
    endgenerate

    // A single load-use hazard regardless of how many operands match
    assign w_hazard = id_valid_i && !flush_i && ex_memread_i && w_exWriter && (|w_idMatchEx);

    // State register for the stall sequencer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_remain <= w_remainNext;
        end
    end

    // Next-state and stall decision; STALL holds for the remaining load latency
    always_comb begin
        w_stateNext  = r_state;
        w_remainNext = r_remain;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_stateNext  = ST_STALL;
                        w_remainNext = LAT_M1;
                    end
                end
            end
            ST_STALL: begin
                if (flush_i) begin
                    w_stateNext  = ST_IDLE;
                    w_remainNext = '0;
                end else begin
                    w_stall = 1'b1;
                    if (r_remain <= 3'd1) begin
                        w_stateNext  = ST_IDLE;
                        w_remainNext = '0;
                    end else begin
                        w_remainNext = r_remain - 3'd1;
                    end
                end
            end
            default: begin
                w_stateNext  = ST_IDLE;
                w_remainNext = '0;
            end
        endcase
    end

    generate
        if (REG_FWD != 0) begin : g_regfwd
            logic [2*NUM_SRC-1:0] r_fwdSel;
            // Selects computed in ID, captured into EX; squashed slots forward nothing
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_fwdSel <= '0;
                end else if (w_stall || flush_i || !id_valid_i) begin
                    r_fwdSel <= '0;
                end else begin
                    r_fwdSel <= w_selCalc;
                end
            end
            assign w_fwdSel = r_fwdSel;
        end else begin : g_combfwd
            assign w_fwdSel = w_selCalc;
        end
    endgenerate

    // Saturating count of bubble cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stallCnt <= '0;
        end else if (idex_bubble_o && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    assign fwd_sel_o     = rst_i ? '0 : w_fwdSel;
    assign pc_write_o    = rst_i || !w_stall;
    assign ifid_write_o  = rst_i || !w_stall;
    assign idex_bubble_o = !rst_i && w_stall;
    assign stall_cnt_o   = r_stallCnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. Four instances share one set of inputs:
// A = comb forwarding, LOAD_LAT=1; B = LOAD_LAT=3; C = registered forwarding;
// D = LOAD_LAT=1 with a 2-bit stall counter to reach saturation quickly.
module tb_hazard_fwd_unit;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        id_valid_i;
    logic [9:0]  id_rs_i;
    logic [9:0]  ex_rs_i;
    logic        ex_regwrite_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic        mem_regwrite_i;
    logic [4:0]  mem_rd_i;
    logic        wb_regwrite_i;
    logic [4:0]  wb_rd_i;

    logic [3:0]  aFwd,   bFwd,   cFwd,   dFwd;
    logic [1:0]  aByp,   bByp,   cByp,   dByp;
    logic        aPc,    bPc,    cPc,    dPc;
    logic        aIfid,  bIfid,  cIfid,  dIfid;
    logic        aBub,   bBub,   cBub,   dBub;
    logic [31:0] aCnt,   bCnt,   cCnt;
    logic [1:0]  dCnt;

    int total = 0;
    int bad   = 0;

    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .REG_FWD(0), .CNT_W(32)) dutA (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .ex_rs_i(ex_rs_i), .ex_regwrite_i(ex_regwrite_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .mem_regwrite_i(mem_regwrite_i),
        .mem_rd_i(mem_rd_i), .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i),
        .fwd_sel_o(aFwd), .id_bypass_o(aByp), .pc_write_o(aPc), .ifid_write_o(aIfid),
        .idex_bubble_o(aBub), .stall_cnt_o(aCnt));

    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .REG_FWD(0), .CNT_W(32)) dutB (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .ex_rs_i(ex_rs_i), .ex_regwrite_i(ex_regwrite_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .mem_regwrite_i(mem_regwrite_i),
        .mem_rd_i(mem_rd_i), .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i),
        .fwd_sel_o(bFwd), .id_bypass_o(bByp), .pc_write_o(bPc), .ifid_write_o(bIfid),
        .idex_bubble_o(bBub), .stall_cnt_o(bCnt));

    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .REG_FWD(1), .CNT_W(32)) dutC (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .ex_rs_i(ex_rs_i), .ex_regwrite_i(ex_regwrite_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .mem_regwrite_i(mem_regwrite_i),
        .mem_rd_i(mem_rd_i), .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i),
        .fwd_sel_o(cFwd), .id_bypass_o(cByp), .pc_write_o(cPc), .ifid_write_o(cIfid),
        .idex_bubble_o(cBub), .stall_cnt_o(cCnt));

    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .REG_FWD(0), .CNT_W(2)) dutD (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .ex_rs_i(ex_rs_i), .ex_regwrite_i(ex_regwrite_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .mem_regwrite_i(mem_regwrite_i),
        .mem_rd_i(mem_rd_i), .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i),
        .fwd_sel_o(dFwd), .id_bypass_o(dByp), .pc_write_o(dPc), .ifid_write_o(dIfid),
        .idex_bubble_o(dBub), .stall_cnt_o(dCnt));

    // 10 ns clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic clearInputs();
        flush_i        = 1'b0;
        id_valid_i     = 1'b0;
        id_rs_i        = '0;
        ex_rs_i        = '0;
        ex_regwrite_i  = 1'b0;
        ex_memread_i   = 1'b0;
        ex_rd_i        = '0;
        mem_regwrite_i = 1'b0;
        mem_rd_i       = '0;
        wb_regwrite_i  = 1'b0;
        wb_rd_i        = '0;
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic stepClk();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
    endtask

    // Load in EX writing r7, consumer in ID reading r7 on the given operands
    task automatic applyLoadHazard(input logic [9:0] rs);
        id_valid_i    = 1'b1;
        id_rs_i       = rs;
        ex_memread_i  = 1'b1;
        ex_regwrite_i = 1'b1;
        ex_rd_i       = 5'd7;
    endtask

    task automatic test_reset();
        clearInputs();
        rst_i = 1'b1;
        applyLoadHazard({5'd7, 5'd3});
        ex_rs_i        = {5'd0, 5'd5};
        mem_regwrite_i = 1'b1;
        mem_rd_i       = 5'd5;
        #2;
        total++; if (bPc !== 1'b1) begin bad++; $display("[TB] FAIL reset_pc_write: got %b expected 1", bPc); end
        total++; if (bIfid !== 1'b1) begin bad++; $display("[TB] FAIL reset_ifid_write: got %b expected 1", bIfid); end
        total++; if (bBub !== 1'b0) begin bad++; $display("[TB] FAIL reset_bubble: got %b expected 0", bBub); end
        total++; if (bFwd !== 4'b0000) begin bad++; $display("[TB] FAIL reset_fwd_sel: got %b expected 0000", bFwd); end
        total++; if (bCnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", bCnt); end
        total++; if (cFwd !== 4'b0000) begin bad++; $display("[TB] FAIL reset_regfwd_sel: got %b expected 0000", cFwd); end
        doReset();
    endtask

    task automatic test_forward_comb();
        doReset();
        ex_rs_i        = {5'd0, 5'd5};
        mem_regwrite_i = 1'b1;
        mem_rd_i       = 5'd5;
        wb_regwrite_i  = 1'b1;
        wb_rd_i        = 5'd5;
        #1;
        total++; if (aFwd !== 4'b0010) begin bad++; $display("[TB] FAIL fwd_exmem_priority: got %b expected 0010", aFwd); end
        mem_regwrite_i = 1'b0;
        #1;
        total++; if (aFwd !== 4'b0001) begin bad++; $display("[TB] FAIL fwd_memwb: got %b expected 0001", aFwd); end
        mem_regwrite_i = 1'b1;
        mem_rd_i       = 5'd0;
        wb_rd_i        = 5'd0;
        #1;
        total++; if (aFwd !== 4'b0000) begin bad++; $display("[TB] FAIL fwd_rd_zero: got %b expected 0000", aFwd); end
        ex_rs_i        = {5'd12, 5'd0};
        mem_rd_i       = 5'd12;
        wb_rd_i        = 5'd0;
        #1;
        total++; if (aFwd !== 4'b1000) begin bad++; $display("[TB] FAIL fwd_operand1_exmem: got %b expected 1000", aFwd); end
        ex_rs_i        = {5'd9, 5'd9};
        mem_rd_i       = 5'd4;
        wb_rd_i        = 5'd9;
        #1;
        total++; if (aFwd !== 4'b0101) begin bad++; $display("[TB] FAIL fwd_both_memwb: got %b expected 0101", aFwd); end
    endtask

    task automatic test_load_lat1();
        doReset();
        applyLoadHazard({5'd7, 5'd3});
        #1;
        total++; if ({aPc, aIfid, aBub} !== 3'b001) begin bad++; $display("[TB] FAIL lat1_stall: got pc/ifid/bub=%b expected 001", {aPc, aIfid, aBub}); end
        total++; if (aCnt !== 32'd0) begin bad++; $display("[TB] FAIL lat1_cnt_before: got %0d expected 0", aCnt); end
        stepClk();
        ex_memread_i  = 1'b0;
        ex_regwrite_i = 1'b0;
        #1;
        total++; if ({aPc, aIfid, aBub} !== 3'b110) begin bad++; $display("[TB] FAIL lat1_release: got pc/ifid/bub=%b expected 110", {aPc, aIfid, aBub}); end
        total++; if (aCnt !== 32'd1) begin bad++; $display("[TB] FAIL lat1_cnt_after: got %0d expected 1", aCnt); end
    endtask

    task automatic test_load_lat3();
        doReset();
        applyLoadHazard({5'd7, 5'd7});
        #1;
        total++; if (bBub !== 1'b1) begin bad++; $display("[TB] FAIL lat3_stall_c0: got %b expected 1", bBub); end
        stepClk();
        ex_memread_i  = 1'b0;
        ex_regwrite_i = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #1;
            total++; if ({bPc, bIfid, bBub} !== 3'b001) begin bad++; $display("[TB] FAIL lat3_stall_c%0d: got pc/ifid/bub=%b expected 001", i, {bPc, bIfid, bBub}); end
            stepClk();
        end
        #1;
        total++; if ({bPc, bIfid, bBub} !== 3'b110) begin bad++; $display("[TB] FAIL lat3_release: got pc/ifid/bub=%b expected 110", {bPc, bIfid, bBub}); end
        total++; if (bCnt !== 32'd3) begin bad++; $display("[TB] FAIL lat3_cnt: got %0d expected 3", bCnt); end
    endtask

    task automatic test_flush_mid_stall();
        doReset();
        applyLoadHazard({5'd3, 5'd7});
        #1;
        total++; if (bBub !== 1'b1) begin bad++; $display("[TB] FAIL flush_first_stall: got %b expected 1", bBub); end
        stepClk();
        ex_memread_i  = 1'b0;
        ex_regwrite_i = 1'b0;
        flush_i       = 1'b1;
        #1;
        total++; if ({bPc, bIfid, bBub} !== 3'b110) begin bad++; $display("[TB] FAIL flush_drop: got pc/ifid/bub=%b expected 110", {bPc, bIfid, bBub}); end
        stepClk();
        flush_i = 1'b0;
        #1;
        total++; if (bBub !== 1'b0) begin bad++; $display("[TB] FAIL flush_back_idle: got %b expected 0", bBub); end
        total++; if (bCnt !== 32'd1) begin bad++; $display("[TB] FAIL flush_cnt: got %0d expected 1", bCnt); end
    endtask

    task automatic test_reg_fwd();
        doReset();
        id_valid_i    = 1'b1;
        id_rs_i       = {5'd0, 5'd4};
        ex_regwrite_i = 1'b1;
        ex_rd_i       = 5'd4;
        #1;
        total++; if (cFwd !== 4'b0000) begin bad++; $display("[TB] FAIL regfwd_not_yet: got %b expected 0000", cFwd); end
        stepClk();
        clearInputs();
        #1;
        total++; if (cFwd !== 4'b0010) begin bad++; $display("[TB] FAIL regfwd_ex: got %b expected 0010", cFwd); end
        id_valid_i     = 1'b1;
        id_rs_i        = {5'd4, 5'd0};
        mem_regwrite_i = 1'b1;
        mem_rd_i       = 5'd4;
        stepClk();
        #1;
        total++; if (cFwd !== 4'b0100) begin bad++; $display("[TB] FAIL regfwd_mem: got %b expected 0100", cFwd); end
        clearInputs();
        id_valid_i    = 1'b1;
        id_rs_i       = {5'd0, 5'd4};
        ex_regwrite_i = 1'b1;
        ex_rd_i       = 5'd4;
        flush_i       = 1'b1;
        stepClk();
        #1;
        total++; if (cFwd !== 4'b0000) begin bad++; $display("[TB] FAIL regfwd_flush: got %b expected 0000", cFwd); end
    endtask

    task automatic test_bypass();
        doReset();
        wb_regwrite_i = 1'b1;
        wb_rd_i       = 5'd9;
        id_rs_i       = {5'd9, 5'd2};
        #1;
        total++; if (aByp !== 2'b10) begin bad++; $display("[TB] FAIL bypass_op1: got %b expected 10", aByp); end
        total++; if (cByp !== 2'b10) begin bad++; $display("[TB] FAIL bypass_regfwd_op1: got %b expected 10", cByp); end
        wb_regwrite_i = 1'b0;
        #1;
        total++; if (aByp !== 2'b00) begin bad++; $display("[TB] FAIL bypass_no_rw: got %b expected 00", aByp); end
        wb_regwrite_i = 1'b1;
        wb_rd_i       = 5'd0;
        id_rs_i       = {5'd0, 5'd0};
        #1;
        total++; if (aByp !== 2'b00) begin bad++; $display("[TB] FAIL bypass_r0: got %b expected 00", aByp); end
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        applyLoadHazard({5'd7, 5'd1});
        ex_rs_i        = {5'd0, 5'd6};
        mem_regwrite_i = 1'b1;
        mem_rd_i       = 5'd6;
        stepClk();
        #1;
        total++; if (bBub !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_in_stall: got %b expected 1", bBub); end
        rst_i = 1'b1;
        #1;
        total++; if ({bPc, bIfid, bBub} !== 3'b110) begin bad++; $display("[TB] FAIL rstmid_ctrl: got pc/ifid/bub=%b expected 110", {bPc, bIfid, bBub}); end
        total++; if (bFwd !== 4'b0000) begin bad++; $display("[TB] FAIL rstmid_fwd: got %b expected 0000", bFwd); end
        total++; if (bCnt !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_cnt: got %0d expected 0", bCnt); end
        clearInputs();
        #1;
        rst_i = 1'b0;
        stepClk();
        #1;
        total++; if (bBub !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_leak: got %b expected 0", bBub); end
        total++; if (bCnt !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_cnt_after: got %0d expected 0", bCnt); end
    endtask

    task automatic test_saturation();
        doReset();
        applyLoadHazard({5'd7, 5'd7});
        repeat (2) stepClk();
        total++; if (dCnt !== 2'd2) begin bad++; $display("[TB] FAIL sat_cnt2: got %0d expected 2", dCnt); end
        stepClk();
        total++; if (dCnt !== 2'd3) begin bad++; $display("[TB] FAIL sat_cnt3: got %0d expected 3", dCnt); end
        repeat (3) stepClk();
        total++; if (dCnt !== 2'd3) begin bad++; $display("[TB] FAIL sat_hold: got %0d expected 3", dCnt); end
        total++; if (dBub !== 1'b1) begin bad++; $display("[TB] FAIL sat_still_stalling: got %b expected 1", dBub); end
        clearInputs();
    endtask

    // Scenario sequence
    initial begin
        rst_i = 1'b0;
        clearInputs();
        #1;
        $display("[TB] hazard_fwd_unit bench start");
        test_reset();
        test_forward_comb();
        test_load_lat1();
        test_load_lat3();
        test_flush_mid_stall();
        test_reg_fwd();
        test_bypass();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised successor of the EX-stage forwarding unit. Combines operand forwarding for NUM_SRC source operands with load-use hazard detection and a stall sequencer. The sequencer supports multi-cycle load latency. Sits between the ID/EX pipeline registers and the PC / IF-ID write enables. Optional registered-forwarding mode precomputes selects in ID for timing.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction (1..4)
LOAD_LAT, 1, bubbles required between a load in EX and a dependent consumer (1..7)
REG_FWD, 0, 0 = selects computed combinationally in EX; 1 = selects computed in ID and registered into EX
CNT_W, 32, stall performance-counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  ID instruction squashed (branch/jump taken)
id_valid_i  in  1  ID holds a real instruction
id_rs_i  in  NUM_SRC*REG_AW  ID source regs; operand k at [k*REG_AW +: REG_AW]
ex_rs_i  in  NUM_SRC*REG_AW  ID/EX source regs (used when REG_FWD=0)
ex_regwrite_i  in  1  ID/EX RegWrite
ex_memread_i  in  1  ID/EX MemRead
ex_rd_i  in  REG_AW  ID/EX destination
mem_regwrite_i  in  1  EX/MEM RegWrite
mem_rd_i  in  REG_AW  EX/MEM destination
wb_regwrite_i  in  1  MEM/WB RegWrite
wb_rd_i  in  REG_AW  MEM/WB destination
fwd_sel_o  out  2*NUM_SRC  per-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
id_bypass_o  out  NUM_SRC  per-operand WB-to-ID regfile write-through
pc_write_o  out  1  PC write enable
ifid_write_o  out  1  IF/ID write enable
idex_bubble_o  out  1  zero ID/EX control this cycle
stall_cnt_o  out  CNT_W  total stall cycles since reset

Behaviour:
- Reset (async): state IDLE, remaining count 0, registered selects 0, stall_cnt_o 0. Outputs during reset: pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, fwd_sel_o=0.
- Destination match rule: writer valid only if its RegWrite=1 and rd != 0. Register 0 never forwards, stalls or bypasses.
- Forward select, REG_FWD=0: combinational per operand k from ex_rs_i[k]. EX/MEM match -> 10; else MEM/WB match -> 01; else 00. EX/MEM has priority.
- Forward select, REG_FWD=1: computed from id_rs_i[k]. ex_* match -> 10; else mem_* match -> 01; else 00. Result registered on clk_i, so it appears one cycle later aligned with EX. Register loads 0 when stalling, flush_i=1, or id_valid_i=0. ex_rs_i is ignored in this mode.
- id_bypass_o[k] = wb writer valid and wb_rd_i == id_rs_i[k]. Combinational in both modes.
- Hazard condition: id_valid_i, !flush_i, ex_memread_i, ex writer valid, and ex_rd_i equals any id_rs_i[k].
- FSM states: IDLE, STALL.
  - IDLE: on hazard, assert stall outputs in the same cycle (pc_write_o=0, ifid_write_o=0, idex_bubble_o=1). If LOAD_LAT>1, go to STALL with remaining count = LOAD_LAT-1; otherwise stay in IDLE.
  - STALL: assert stall outputs unconditionally. Decrement the count each cycle; return to IDLE when the count reaches 1.
  - flush_i in STALL: return to IDLE immediately, deassert stall outputs that cycle, clear the count.
- A new hazard is re-evaluated in IDLE after a stall completes. With LOAD_LAT=1, the bubble clears ex_memread_i, so no repeat stall.
- stall_cnt_o increments on every cycle idex_bubble_o=1. It saturates at all-ones and never wraps.
- Multiple operands matching at once produce one stall sequence, not one per operand.
- Reset mid-stall: immediate return to IDLE; no stall cycles leak after reset release.

Decomposition:
- Shared package: fwd_sel encodings (FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01) and FSM state encoding. These are shared with the datapath operand muxes.
- One natural sub-module, fwd_sel_cmp: single-operand priority comparator (rs, two writers -> 2-bit select).
  - Instantiate it NUM_SRC times, for EX or ID inputs depending on REG_FWD.
  - The WB bypass compare is inline.

Test Plan:
- REG_FWD=0, ex_rs=5, mem_rd=5 (rw=1), wb_rd=5 (rw=1) -> fwd_sel_o operand 0 = 10. Drop mem_regwrite -> 01. Set mem_rd=0 and wb_rd=0 -> 00.
- LOAD_LAT=1, ex load rd=7, id_rs1=7 -> exactly one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. stall_cnt_o goes 0 -> 1.
- LOAD_LAT=3, same hazard held -> 3 consecutive stall cycles, then release. stall_cnt_o=3.
- LOAD_LAT=3, flush_i asserted in 2nd stall cycle -> stall outputs drop that cycle, FSM back to IDLE, stall_cnt_o=1.
- REG_FWD=1, id_rs0=4, ex_rd=4 (rw=1, not load) -> fwd_sel_o=10 one clock later. Same stimulus with flush_i=1 -> 00.
- wb_rd=9 (rw=1), id_rs1=9 -> id_bypass_o=2'b10. Async rst_i mid-stall -> all outputs to reset values without a clock edge.
